// File: rtl/immediate_gen.sv
// RV32I immediate extractor: opcode-selected 12-bit immediate, registered with a valid flag.
// Optional IMM_SEXT32_EN adds a registered 32-bit sign-extended immediate (imm32).
module immediate_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    output logic [11:0] immediate,
    output logic        out_valid,
    output logic        imm_none
`ifdef IMM_SEXT32_EN
    ,
    output logic [31:0] imm32
`endif
);

    localparam int unsigned IMM_W   = 12;
    localparam int unsigned WORD_W  = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [IMM_W-1:0]  dec_imm;
    logic              dec_none;
    logic [WORD_W-1:0] dec_imm32;

    logic [IMM_W-1:0]  immediate_d, immediate_q;
    logic              out_valid_d, out_valid_q;
    logic              imm_none_d,  imm_none_q;

    // rs1/funct3 field never contributes to any supported immediate
    logic unused_bits;
    assign unused_bits = ^instruction[19:12];

    // Field layout selected purely by opcode
    always_comb begin
        dec_imm   = '0;
        dec_none  = 1'b0;
        dec_imm32 = '0;
        unique case (instruction[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                dec_imm   = instruction[31:20];
                dec_imm32 = {{(WORD_W-IMM_W){dec_imm[IMM_W-1]}}, dec_imm};
            end
            OPC_STORE: begin
                dec_imm   = {instruction[31:25], instruction[11:7]};
                dec_imm32 = {{(WORD_W-IMM_W){dec_imm[IMM_W-1]}}, dec_imm};
            end
            OPC_BRANCH: begin
                dec_imm   = {instruction[31], instruction[7], instruction[30:25], instruction[11:8]};
                // Branch offsets are halfword-scaled; restore the implicit zero LSB
                dec_imm32 = {{(WORD_W-IMM_W-1){dec_imm[IMM_W-1]}}, dec_imm, 1'b0};
            end
            default: begin
                dec_none = 1'b1;
            end
        endcase
    end

    // Load on accept, hold otherwise
    always_comb begin
        immediate_d = immediate_q;
        imm_none_d  = imm_none_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            immediate_d = dec_imm;
            imm_none_d  = dec_none;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            immediate_q <= '0;
            out_valid_q <= 1'b0;
            imm_none_q  <= 1'b0;
        end else begin
            immediate_q <= immediate_d;
            out_valid_q <= out_valid_d;
            imm_none_q  <= imm_none_d;
        end
    end

    assign immediate = immediate_q;
    assign out_valid = out_valid_q;
    assign imm_none  = imm_none_q;

`ifdef IMM_SEXT32_EN
    logic [WORD_W-1:0] imm32_d, imm32_q;

    always_comb begin
        imm32_d = imm32_q;
        if (in_valid) begin
            imm32_d = dec_imm32;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imm32_q <= '0;
        end else begin
            imm32_q <= imm32_d;
        end
    end

    assign imm32 = imm32_q;
`else
    logic unused_imm32;
    assign unused_imm32 = ^dec_imm32;
`endif

endmodule

// File: tb/tb_immediate_gen.sv
// Scoreboard bench for immediate_gen; expectations come from an independent opcode model.
// Covers imm32 when IMM_SEXT32_EN is defined.
module tb_immediate_gen;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instruction;
    logic [11:0] immediate;
    logic        out_valid;
    logic        imm_none;
`ifdef IMM_SEXT32_EN
    logic [31:0] imm32;
`endif

    immediate_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .instruction (instruction),
        .immediate   (immediate),
        .out_valid   (out_valid),
        .imm_none    (imm_none)
`ifdef IMM_SEXT32_EN
        ,
        .imm32       (imm32)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [11:0] imm;
        logic        none;
        logic [31:0] imm32;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model output registers
    logic [11:0] m_imm   = 12'h000;
    logic        m_none  = 1'b0;
    logic [31:0] m_imm32 = 32'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decode, written from the instruction-format tables
    task automatic ref_decode(input logic [31:0] ins, output logic [11:0] imm,
                              output logic none, output logic [31:0] i32);
        logic [12:0] boff;
        imm  = 12'h000;
        none = 1'b0;
        i32  = 32'h0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: begin
                imm = ins[31:20];
                i32 = 32'($signed(ins[31:20]));
            end
            7'h23: begin
                imm = {ins[31:25], ins[11:7]};
                i32 = 32'($signed(imm));
            end
            7'h63: begin
                boff = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                imm  = boff[12:1];
                i32  = 32'($signed(boff));
            end
            default: none = 1'b1;
        endcase
    endtask

    // Drive one cycle, push expectation, pop and compare after the edge
    task automatic step(input logic rst, input logic v, input logic [31:0] ins, input string tag);
        exp_t        e;
        exp_t        got_e;
        logic [11:0] di;
        logic        dn;
        logic [31:0] d32;
        @(negedge clk);
        rst_n       = rst;
        in_valid    = v;
        instruction = ins;
        ref_decode(ins, di, dn, d32);
        if (!rst) begin
            m_imm = 12'h000; m_none = 1'b0; m_imm32 = 32'h0;
            e.valid = 1'b0;
        end else begin
            if (v) begin
                m_imm = di; m_none = dn; m_imm32 = d32;
            end
            e.valid = v;
        end
        e.imm = m_imm; e.none = m_none; e.imm32 = m_imm32;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty got 0 entries expected 1", tag);
        end else begin
            got_e = q.pop_front();
            check_val({tag, ".out_valid"}, 32'(out_valid), 32'(got_e.valid));
            check_val({tag, ".immediate"}, 32'(immediate), 32'(got_e.imm));
            check_val({tag, ".imm_none"},  32'(imm_none),  32'(got_e.none));
`ifdef IMM_SEXT32_EN
            check_val({tag, ".imm32"},     imm32,          got_e.imm32);
`endif
        end
    endtask

    logic [6:0] opc_tab [8];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instruction = 32'h0;
        opc_tab[0] = 7'h03; opc_tab[1] = 7'h13; opc_tab[2] = 7'h67; opc_tab[3] = 7'h23;
        opc_tab[4] = 7'h63; opc_tab[5] = 7'h00; opc_tab[6] = 7'h7f; opc_tab[7] = 7'h37;

        // Reset dominates in_valid
        step(1'b0, 1'b1, 32'h5557FF83, "rst0");
        step(1'b0, 1'b1, 32'h5557FF83, "rst1");
        step(1'b1, 1'b0, 32'h5557FF83, "idle");

        step(1'b1, 1'b1, 32'hFFFFFF80, "unsup");
        step(1'b1, 1'b1, 32'h0FFFFF63, "beq");
        step(1'b1, 1'b1, 32'h5557FF83, "lw");
        step(1'b1, 1'b1, 32'h55FFFAA3, "sw");
        step(1'b1, 1'b0, 32'h0FFFFF63, "hold");
        step(1'b1, 1'b1, 32'h5557FF83, "b2b_lw");
        step(1'b1, 1'b1, 32'h0FFFFF63, "b2b_beq");
        step(1'b1, 1'b1, 32'hFFFFFFFF, "allones");
        step(1'b1, 1'b1, 32'h80000067, "jalr_neg");
        step(1'b1, 1'b1, 32'hFE000FE3, "beq_neg");
        // Reset mid-stream discards the pending result
        step(1'b0, 1'b1, 32'h7FF00013, "mid_rst");
        step(1'b1, 1'b1, 32'h7FF00013, "addi_max");

        for (int i = 0; i < 60; i++) begin
            logic [31:0] r;
            r      = $urandom;
            r[6:0] = opc_tab[$urandom_range(0, 7)];
            step(1'b1, 1'($urandom_range(0, 3) != 0), r, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/immediate_gen.md
Name: immediate_gen

Overview:
- Immediate extractor for the RV32I decode stage.
- Takes a 32-bit instruction word, selects the immediate field layout from the opcode (inst[6:0]), and outputs a 12-bit packed immediate.
- Output is registered (1-cycle latency) with a valid flag. It feeds the ALU operand mux, the branch-target adder and the load/store address adder.

Parameters:
- none (widths fixed by the RV32I encoding)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  instruction word on `instruction` is valid this cycle
- instruction  input  32  raw instruction word
- immediate  output  12  packed immediate, registered
- out_valid  output  1  `immediate` corresponds to an instruction accepted the previous cycle
- imm_none  output  1  registered; opcode carries no supported 12-bit immediate

Behaviour:
- One clock domain (clk); reset is synchronous and active-low (rst_n); only clk and rst_n, no other clock or reset.
- Reset: on a rising clk edge with rst_n=0, immediate=12'h000, out_valid=0, imm_none=0. Reset dominates in_valid. Reset mid-stream discards the in-flight result.
- Latency is exactly 1 cycle. At each rising edge with rst_n=1:
  - out_valid <= in_valid.
  - If in_valid=1, immediate and imm_none are loaded from the decode below.
  - If in_valid=0, immediate and imm_none hold their previous values.
- No backpressure; a new instruction may be accepted every cycle.
- Decode by opcode = instruction[6:0]:
  - 0000011 (LOAD, I-type): immediate = instruction[31:20]
  - 0010011 (OP-IMM, I-type): immediate = instruction[31:20]
  - 1100111 (JALR, I-type): immediate = instruction[31:20]
  - 0100011 (STORE, S-type): immediate = {instruction[31:25], instruction[11:7]}
  - 1100011 (BRANCH, B-type, offset bits [12:1]): immediate = {instruction[31], instruction[7], instruction[30:25], instruction[11:8]}. Implicit bit 0 is not output; downstream shifts left by 1.
  - Any other opcode (including 0000000 and all-ones): immediate = 12'h000, imm_none = 1.
- imm_none = 0 for the five supported opcodes.
- funct3/funct7 are ignored; decode depends only on instruction[6:0].
- No sign extension inside the 12-bit output; bit 11 is the sign bit.
- Purely combinational decode feeding the output register; no internal state beyond the registers.

Optional Feature:
- Macro: IMM_SEXT32_EN.
- Defined:
  - Adds output port imm32 (32-bit, registered alongside `immediate`, same enable and reset value 32'h0).
  - I/S types: imm32 = sign-extend of `immediate`.
  - B type: imm32 = sign-extend of {immediate, 1'b0}.
  - Unsupported opcodes: 0.
- Not defined: port imm32 and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and an arbitrary instruction -> immediate=000000000000, out_valid=0, imm_none=0; release rst_n -> first result appears 1 cycle after the next accepted instruction.
- Unsupported opcode: instruction=32'hFFFFFF80 (opcode 0000000), in_valid=1 -> next cycle immediate=000000000000, imm_none=1, out_valid=1.
- BEQ: instruction=32'h0FFFFF63 -> next cycle immediate=000001111111, imm_none=0.
- LW: instruction=32'h5557FF83 -> next cycle immediate=010101010101.
- SW: instruction=32'h55FFFAA3 -> next cycle immediate=010101010101. Then in_valid=0 with a different instruction -> immediate holds 010101010101, out_valid=0.
- Back-to-back: LW 32'h5557FF83 then BEQ 32'h0FFFFF63 on consecutive cycles -> outputs 010101010101 then 000001111111 on consecutive cycles, out_valid=1 both cycles. With IMM_SEXT32_EN, the BEQ gives imm32=32'h000000FE.
